// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED path: channel selector codes, colour-wheel
// phase and sequencer state encodings, and per-phase channel/direction tables.
package rgb_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_RED   = 2'b00;
    localparam sel_t SEL_GREEN = 2'b01;
    localparam sel_t SEL_BLUE  = 2'b10;

    localparam logic [2:0] PH0 = 3'd0;
    localparam logic [2:0] PH1 = 3'd1;
    localparam logic [2:0] PH2 = 3'd2;
    localparam logic [2:0] PH3 = 3'd3;
    localparam logic [2:0] PH4 = 3'd4;
    localparam logic [2:0] PH5 = 3'd5;

    localparam logic [1:0] ST_INIT_R = 2'd0;
    localparam logic [1:0] ST_INIT_G = 2'd1;
    localparam logic [1:0] ST_INIT_B = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // Wheel order: G up, R down, B up, G down, R up, B down.
    function automatic sel_t phase_channel(input logic [2:0] phase);
        sel_t ch;
        case (phase)
            PH0, PH3: ch = SEL_GREEN;
            PH1, PH4: ch = SEL_RED;
            default:  ch = SEL_BLUE;
        endcase
        return ch;
    endfunction

    function automatic logic phase_up(input logic [2:0] phase);
        logic up;
        case (phase)
            PH0, PH2, PH4: up = 1'b1;
            default:       up = 1'b0;
        endcase
        return up;
    endfunction

    function automatic logic [2:0] phase_next(input logic [2:0] phase);
        logic [2:0] nxt;
        if (phase >= PH5) begin
            nxt = PH0;
        end else begin
            nxt = phase + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Step-rate divider: counts enabled cycles and pulses tick for one cycle at
// the wrap; the count freezes while run is low and clear forces it to zero.
module rgb_tick_gen #(
    parameter int STEP_TICKS = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    // Cycle counter between wheel steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= {CW{1'b0}};
        end else if (clear) begin
            cnt <= {CW{1'b0}};
        end else if (run) begin
            if (cnt == LAST) begin
                cnt <= {CW{1'b0}};
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/rgb_color_sequencer.sv
// Hue-wheel generator: walks R/G/B levels around a six-phase wheel and issues
// one-cycle write strobes to the downstream RGB LED stage.
module rgb_color_sequencer
    import rgb_pkg::*;
#(
    parameter int R          = 8,
    parameter int STEP_TICKS = 1_000_000,
    parameter int STEP       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       restart,
    output logic [1:0] color_selector,
    output logic [R:0] color_intensity,
    output logic       change_color
);

    localparam logic [R:0]   MAX    = {1'b1, {R{1'b0}}};
    localparam logic [R+1:0] STEP_W = STEP[R+1:0];

    logic [1:0]   state;
    logic [2:0]   phase;
    logic [R:0]   lvl_r;
    logic [R:0]   lvl_g;
    logic [R:0]   lvl_b;
    logic         tick;
    logic         run;
    logic         clear;
    sel_t         cur_sel;
    logic         cur_up;
    logic [R:0]   cur_lvl;
    logic [R+1:0] sum;
    logic [R:0]   new_lvl;
    logic         wrap;

    assign run   = (state == ST_RUN) && enable && !restart;
    assign clear = (state != ST_RUN) || restart;

    rgb_tick_gen #(.STEP_TICKS(STEP_TICKS)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (clear),
        .tick  (tick)
    );

    // Next level of the active channel; wrap marks the last step of a phase.
    always_comb begin
        cur_sel = phase_channel(phase);
        cur_up  = phase_up(phase);
        case (cur_sel)
            SEL_RED:   cur_lvl = lvl_r;
            SEL_GREEN: cur_lvl = lvl_g;
            default:   cur_lvl = lvl_b;
        endcase
        sum = {1'b0, cur_lvl} + STEP_W;
        if (cur_up) begin
            if (sum >= {1'b0, MAX}) begin
                new_lvl = MAX;
                wrap    = 1'b1;
            end else begin
                new_lvl = sum[R:0];
                wrap    = 1'b0;
            end
        end else begin
            if ({1'b0, cur_lvl} <= STEP_W) begin
                new_lvl = {(R+1){1'b0}};
                wrap    = 1'b1;
            end else begin
                new_lvl = cur_lvl - STEP_W[R:0];
                wrap    = 1'b0;
            end
        end
    end

    // Sequencer FSM, level/phase registers and registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_INIT_R;
            phase           <= PH0;
            lvl_r           <= {(R+1){1'b0}};
            lvl_g           <= {(R+1){1'b0}};
            lvl_b           <= {(R+1){1'b0}};
            change_color    <= 1'b0;
            color_selector  <= SEL_RED;
            color_intensity <= {(R+1){1'b0}};
        end else begin
            change_color <= 1'b0;
            if (restart) begin
                state <= ST_INIT_R;
            end else begin
                if (state != ST_RUN) begin
                    lvl_r <= MAX;
                    lvl_g <= {(R+1){1'b0}};
                    lvl_b <= {(R+1){1'b0}};
                    phase <= PH0;
                end
                case (state)
                    ST_INIT_R: begin
                        state           <= ST_INIT_G;
                        change_color    <= 1'b1;
                        color_selector  <= SEL_RED;
                        color_intensity <= MAX;
                    end
                    ST_INIT_G: begin
                        state           <= ST_INIT_B;
                        change_color    <= 1'b1;
                        color_selector  <= SEL_GREEN;
                        color_intensity <= {(R+1){1'b0}};
                    end
                    ST_INIT_B: begin
                        state           <= ST_RUN;
                        change_color    <= 1'b1;
                        color_selector  <= SEL_BLUE;
                        color_intensity <= {(R+1){1'b0}};
                    end
                    ST_RUN: begin
                        if (tick) begin
                            case (cur_sel)
                                SEL_RED:   lvl_r <= new_lvl;
                                SEL_GREEN: lvl_g <= new_lvl;
                                default:   lvl_b <= new_lvl;
                            endcase
                            if (wrap) begin
                                phase <= phase_next(phase);
                            end
                            change_color    <= 1'b1;
                            color_selector  <= cur_sel;
                            color_intensity <= new_lvl;
                        end
                    end
                    default: state <= ST_INIT_R;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Randomised scoreboard bench: a wheel model predicts every strobe (cycle,
// channel, level) for a STEP=3 and a STEP=8 instance driven by shared inputs.
module tb_rgb_color_sequencer;

    localparam int R  = 3;
    localparam int ST = 4;
    localparam int MX = 8;

    typedef struct {
        int due;
        int sel;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       restart = 1'b0;
    logic [1:0] sel_a, sel_b;
    logic [R:0] val_a, val_b;
    logic       cc_a, cc_b;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    // model state per instance: 0 -> STEP=3, 1 -> STEP=8
    int lv[2][3];
    int ph[2];
    int ticks[2];
    int init[2];
    int steps[2] = '{3, 8};
    int chan_tab[6] = '{1, 0, 2, 1, 0, 2};
    int up_tab[6] = '{1, 0, 1, 0, 1, 0};

    rgb_color_sequencer #(.R(R), .STEP_TICKS(ST), .STEP(3)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .color_selector(sel_a), .color_intensity(val_a), .change_color(cc_a));

    rgb_color_sequencer #(.R(R), .STEP_TICKS(ST), .STEP(8)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .restart(restart),
        .color_selector(sel_b), .color_intensity(val_b), .change_color(cc_b));

    always #5 clk = ~clk;

    task automatic push(input int k, input int s, input int v);
        exp_t e;
        e.due = cyc + 1;
        e.sel = s;
        e.val = v;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Evaluates the wheel rules for the inputs about to be sampled.
    task automatic model_eval();
        int ch, v;
        bit adv;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                init[k] = 0; ticks[k] = 0; ph[k] = 0;
                lv[k] = '{0, 0, 0};
            end else if (restart) begin
                init[k] = 0; ticks[k] = 0;
            end else if (init[k] < 3) begin
                push(k, init[k], (init[k] == 0) ? MX : 0);
                lv[k] = '{MX, 0, 0};
                ph[k] = 0; ticks[k] = 0;
                init[k]++;
            end else if (enable) begin
                ticks[k]++;
                if (ticks[k] == ST) begin
                    ticks[k] = 0;
                    ch = chan_tab[ph[k]];
                    adv = 0;
                    if (up_tab[ph[k]] == 1) begin
                        v = lv[k][ch] + steps[k];
                        if (v >= MX) begin v = MX; adv = 1; end
                    end else begin
                        v = lv[k][ch] - steps[k];
                        if (v <= 0) begin v = 0; adv = 1; end
                    end
                    lv[k][ch] = v;
                    push(k, ch, v);
                    if (adv) ph[k] = (ph[k] + 1) % 6;
                end
            end
        end
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic mon(input int k, input logic cc, input logic [1:0] s, input logic [R:0] v);
        exp_t e;
        int n;
        n = (k == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            e = (k == 0) ? q0[0] : q1[0];
            if (e.due < cyc) begin
                checks++; failures++;
                $display("FAIL missing_strobe[%0d] cycle=%0d actual=none required=(%0d,%0d)@%0d",
                         k, cyc, e.sel, e.val, e.due);
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                n = n - 1;
                if (n > 0) e = (k == 0) ? q0[0] : q1[0];
            end
        end
        if (cc) begin
            checks++;
            if (n == 0 || e.due != cyc) begin
                failures++;
                $display("FAIL unexpected_strobe[%0d] cycle=%0d actual=(%0d,%0d) required=no strobe",
                         k, cyc, s, v);
            end else begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                if (int'(s) != e.sel || int'(v) != e.val) begin
                    failures++;
                    $display("FAIL strobe_value[%0d] cycle=%0d actual=(%0d,%0d) required=(%0d,%0d)",
                             k, cyc, s, v, e.sel, e.val);
                end
            end
        end
    endtask

    // Monitor: samples both write ports mid-cycle.
    always @(negedge clk) begin
        mon(0, cc_a, sel_a, val_a);
        mon(1, cc_b, sel_b, val_b);
    end

    task automatic check_zero(input string name);
        checks++;
        if (cc_a !== 1'b0 || sel_a !== 2'b00 || val_a !== 4'd0 ||
            cc_b !== 1'b0 || sel_b !== 2'b00 || val_b !== 4'd0) begin
            failures++;
            $display("FAIL %s actual=(%b,%b,%0d)/(%b,%b,%0d) required=(0,00,0)",
                     name, cc_a, sel_a, val_a, cc_b, sel_b, val_b);
        end
    endtask

    initial begin
        int guard;
        for (int k = 0; k < 2; k++) begin
            init[k] = 0; ticks[k] = 0; ph[k] = 0; lv[k] = '{0, 0, 0};
        end
        #1;
        check_zero("reset_outputs");
        cycle();
        check_zero("reset_outputs_held");
        cycle();
        reset = 1'b0;

        // free run past one full wheel
        repeat (19 * ST * 3 + 10) cycle();

        // freeze for 10 cycles starting two cycles after a strobe
        guard = 0;
        while (cc_a !== 1'b1 && guard < 20) begin cycle(); guard++; end
        checks++;
        if (guard >= 20) begin failures++; $display("FAIL wait_strobe actual=timeout required=strobe"); end
        cycle(); cycle();
        enable = 1'b0;
        repeat (10) cycle();
        enable = 1'b1;
        repeat (12) cycle();

        // restart while a tick is due
        guard = 0;
        while (!(init[0] == 3 && ticks[0] == ST - 1) && guard < 20) begin cycle(); guard++; end
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (20) cycle();

        // randomised enable/restart traffic
        repeat (400) begin
            enable = ($urandom_range(0, 9) < 8);
            restart = ($urandom_range(0, 59) == 0);
            cycle();
        end
        enable = 1'b1;
        restart = 1'b0;
        repeat (3 * ST * 3 * 2) cycle();

        // asynchronous reset during a strobe cycle in P3
        guard = 0;
        while (!(ph[0] == 3 && cc_a === 1'b1) && guard < 300) begin cycle(); guard++; end
        checks++;
        if (guard >= 300) begin failures++; $display("FAIL wait_p3_strobe actual=timeout required=strobe"); end
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        q0.delete();
        q1.delete();
        cycle();
        cycle();
        reset = 1'b0;
        repeat (60) cycle();

        enable = 1'b0;
        repeat (3) cycle();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d/%0d pending required=0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
